conv_mac_unit: RTL and testbench
================================

CONV_MAC_UNIT -- requirements
Module: conv_mac_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, signed width of kernel, input and output samples.
REQ-002 The block SHALL have parameter ACC_W, default 40, signed accumulator width; it SHALL be at least 2*DATA_W.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port kr_data, input, DATA_W: signed kernel sample from kernel memory.
REQ-006 Port in_data, input, DATA_W: signed input sample from input memory.
REQ-007 Port en_mult, input, 1: multiply-stage enable from controller.
REQ-008 Port en_accuml, input, 1: accumulate enable from controller.
REQ-009 Port rst_accuml, input, 1: synchronous accumulator clear from controller.
REQ-010 Port mul_shift, input, 5: arithmetic right shift applied to each product.
REQ-011 Port accu_shift, input, 5: arithmetic right shift applied to the accumulator at output.
REQ-012 Port en_out_mem, input, 1: output-capture strobe (same signal driving output-memory enable).
REQ-013 Port out_data, output, DATA_W: shifted, width-reduced accumulator result.
REQ-014 Port out_valid, output, 1: one-cycle pulse qualifying out_data.
REQ-015 Port mac_count, output, 10: number of products accumulated since last clear.
REQ-016 Port acc_ovf, output, 1: sticky accumulator overflow flag.

Function
REQ-017 Stage 1: when en_mult=1, prod_q SHALL register (kr_data*in_data) >>> mul_shift, sign-extended to ACC_W, and prod_vld SHALL register 1; otherwise prod_vld SHALL register 0 and prod_q SHALL hold.
REQ-018 Stage 2: when en_accuml=1 and prod_vld=1, acc SHALL register acc+prod_q and mac_count SHALL increment.
REQ-019 Latency: product enabled in cycle N SHALL be reflected in acc after the edge closing cycle N+1.
REQ-020 rst_accuml=1 SHALL clear acc, mac_count and acc_ovf; if an accumulate is qualified in the same cycle, acc SHALL load prod_q and mac_count SHALL load 1 (clear-then-add).
REQ-021 en_accuml=1 with prod_vld=0 SHALL leave acc and mac_count unchanged.
REQ-022 mac_count SHALL saturate at 1023 and not wrap.
REQ-023 acc_ovf SHALL set when the signed ACC_W addition overflows; acc SHALL wrap modulo 2^ACC_W.
REQ-024 When en_out_mem=1, out_data SHALL register the reduction of acc >>> accu_shift, using acc's value before any same-cycle update, and out_valid SHALL pulse 1 on the next cycle only.
REQ-025 mul_shift and accu_shift SHALL be sampled in the cycle they are used; no internal copy is kept.

Reset
REQ-026 On rst=1, prod_q, prod_vld, acc, mac_count, acc_ovf, out_data and out_valid SHALL go to 0 immediately, regardless of clk.
REQ-027 A reset during an accumulation SHALL discard any in-flight product; the first qualified accumulate after release SHALL start from 0.

Configuration
REQ-028 With macro CONV_MAC_SATURATE_EN defined, the output reduction SHALL clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-029 Without CONV_MAC_SATURATE_EN, the reduction SHALL truncate to the low DATA_W bits.

Structure
REQ-030 DATA_W default, ACC_W default and shift width 5 SHALL be constants in shared package conv_pkg.
REQ-031 The shift-and-reduce logic SHALL be sub-module conv_sat_shift, instantiated once for the output path.

Verification
REQ-032 kr=3, in=4, mul_shift=0, en_mult then en_accuml next cycle, x4 -> acc=48, mac_count=4.
REQ-033 kr=-5, in=7, mul_shift=1 single MAC -> acc=-18 (arithmetic shift, -35>>>1).
REQ-034 rst_accuml coincident with a qualified accumulate of product 10 after acc=100 -> acc=10, mac_count=1.
REQ-035 acc=1000000, accu_shift=0, en_out_mem -> out_data=32767 with CONV_MAC_SATURATE_EN, 16960 without; out_valid single pulse.
REQ-036 rst asserted mid-way between en_mult and en_accuml -> all outputs 0 at once; later MAC of 2*2 gives acc=4.
REQ-037 1030 consecutive qualified MACs -> mac_count holds 1023.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution MAC datapath.
package conv_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 40;
  localparam int unsigned SHIFT_W    = 5;
  localparam int unsigned CNT_W      = 10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating increment for the MAC counter: sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/conv_sat_shift.sv
// Arithmetic right shift of the accumulator followed by reduction to DATA_W.
// CONV_MAC_SATURATE_EN: clamp to the signed DATA_W range; otherwise keep low bits.
module conv_sat_shift
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  output logic        [DATA_W-1:0]  red_c_o
);

`ifdef CONV_MAC_SATURATE_EN
  logic signed [ACC_W-1:0] shr_c;
  logic                    fits_c;

  assign shr_c = acc_i >>> shift_i;

  // Value fits when all bits from the output sign bit upward agree
  assign fits_c = (&shr_c[ACC_W-1:DATA_W-1]) | ~(|shr_c[ACC_W-1:DATA_W-1]);

  // Clamp toward the most negative or most positive representable sample
  always_comb begin
    red_c_o = shr_c[DATA_W-1:0];
    if (!fits_c) begin
      red_c_o = shr_c[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  // Plain truncation to the low DATA_W bits
  assign red_c_o = DATA_W'(acc_i >>> shift_i);
`endif

endmodule

// File: rtl/conv_mac_unit.sv
// Two-stage multiply-accumulate unit for a convolution engine.
// Stage 1 registers the shifted product, stage 2 accumulates it; an output
// strobe captures the shifted/reduced accumulator. Optional build macro
// CONV_MAC_SATURATE_EN selects clamping instead of truncation at the output.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  kr_data,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               en_mult,
  input  logic               en_accuml,
  input  logic               rst_accuml,
  input  logic [SHIFT_W-1:0] mul_shift,
  input  logic [SHIFT_W-1:0] accu_shift,
  input  logic               en_out_mem,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [CNT_W-1:0]   mac_count,
  output logic               acc_ovf
);

  // ACC_W is expected to be at least 2*DATA_W so the product never truncates
  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_full_c;
  logic signed [PROD_W-1:0] prod_shr_c;
  logic signed [ACC_W-1:0]  prod_ext_c;

  logic signed [ACC_W-1:0]  prod_q, prod_d;
  logic                     prod_vld_q, prod_vld_d;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  acc_base_c, acc_sum_c;
  logic [CNT_W-1:0]         mac_count_q, mac_count_d, cnt_base_c;
  logic                     acc_ovf_q, acc_ovf_d, ovf_base_c;
  logic                     acc_qual_c, add_ovf_c;

  logic [DATA_W-1:0]        out_red_c;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;

  // Signed product, arithmetic shift, sign-extension to accumulator width
  assign prod_full_c = PROD_W'($signed(kr_data)) * PROD_W'($signed(in_data));
  assign prod_shr_c  = prod_full_c >>> mul_shift;
  assign prod_ext_c  = ACC_W'(prod_shr_c);

  // Stage 1 next state: capture product when enabled, otherwise hold it
  always_comb begin
    prod_d     = prod_q;
    prod_vld_d = en_mult;
    if (en_mult) begin
      prod_d = prod_ext_c;
    end
  end

  // Stage 2 next state: clear first, then add a qualified product on top
  always_comb begin
    acc_d       = acc_q;
    mac_count_d = mac_count_q;
    acc_ovf_d   = acc_ovf_q;
    acc_qual_c  = en_accuml & prod_vld_q;
    acc_base_c  = rst_accuml ? '0 : acc_q;
    cnt_base_c  = rst_accuml ? '0 : mac_count_q;
    ovf_base_c  = rst_accuml ? 1'b0 : acc_ovf_q;
    acc_sum_c   = acc_base_c + prod_q;
    add_ovf_c   = (acc_base_c[ACC_W-1] == prod_q[ACC_W-1]) &&
                  (acc_sum_c[ACC_W-1] != acc_base_c[ACC_W-1]);

    acc_d       = acc_base_c;
    mac_count_d = cnt_base_c;
    acc_ovf_d   = ovf_base_c;
    if (acc_qual_c) begin
      acc_d       = acc_sum_c;
      mac_count_d = sat_inc(cnt_base_c);
      acc_ovf_d   = ovf_base_c | add_ovf_c;
    end
  end

  // Output path reduces the pre-update accumulator value
  conv_sat_shift #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_out_shift (
    .acc_i   (acc_q),
    .shift_i (accu_shift),
    .red_c_o (out_red_c)
  );

  // Output capture next state: valid is the strobe delayed by one cycle
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = en_out_mem;
    if (en_out_mem) begin
      out_data_d = out_red_c;
    end
  end

  // Product pipeline registers; reset drops any in-flight product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
    end
  end

  // Accumulator, counter and sticky overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      mac_count_q <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      mac_count_q <= mac_count_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  // Output data and valid-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign mac_count = mac_count_q;
  assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Scoreboard bench for conv_mac_unit: directed scenarios plus random traffic,
// checked against an arithmetic reference model of the MAC behaviour.
module tb_conv_mac_unit;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 40;
  localparam longint ACC_MOD = longint'(1) << AW;
  localparam longint ACC_MAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (AW - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] kr_data, in_data;
  logic          en_mult, en_accuml, rst_accuml, en_out_mem;
  logic [4:0]    mul_shift, accu_shift;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [9:0]    mac_count;
  logic          acc_ovf;

  always #5 clk = ~clk;

  conv_mac_unit #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .kr_data    (kr_data),
    .in_data    (in_data),
    .en_mult    (en_mult),
    .en_accuml  (en_accuml),
    .rst_accuml (rst_accuml),
    .mul_shift  (mul_shift),
    .accu_shift (accu_shift),
    .en_out_mem (en_out_mem),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .mac_count  (mac_count),
    .acc_ovf    (acc_ovf)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  // Reference model state
  longint m_acc  = 0;
  longint m_prod = 0;
  bit     m_vld  = 0;
  int     m_cnt  = 0;
  bit     m_ovf  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected output sample for accumulator value a shifted by sh
  function automatic longint reduce(input longint a, input int sh);
    longint v;
    v = a >>> sh;
`ifdef CONV_MAC_SATURATE_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`else
    v = v & 64'hFFFF;
    if (v >= 32768) v = v - 65536;
`endif
    return v;
  endfunction

  // One clock of the model, using values as they stand before the edge
  task automatic model_step(input int kr, inv, input bit em, ea, ra, input int ms, ash, input bit eo);
    longint base, sum;
    int     cbase;
    bit     obase;
    if (eo) exp_q.push_back(int'(reduce(m_acc, ash)));
    base  = ra ? 0 : m_acc;
    cbase = ra ? 0 : m_cnt;
    obase = ra ? 1'b0 : m_ovf;
    if (ea && m_vld) begin
      sum = base + m_prod;
      if (sum > ACC_MAX) begin
        sum -= ACC_MOD;
        obase = 1'b1;
      end else if (sum < ACC_MIN) begin
        sum += ACC_MOD;
        obase = 1'b1;
      end
      base  = sum;
      cbase = (cbase < 1023) ? cbase + 1 : 1023;
    end
    m_acc = base;
    m_cnt = cbase;
    m_ovf = obase;
    if (em) m_prod = (longint'(kr) * longint'(inv)) >>> ms;
    m_vld = em;
  endtask

  // Apply one cycle of stimulus at the falling edge and check state after it
  task automatic drive(input int kr, inv, input bit em, ea, ra, input int ms, ash, input bit eo);
    kr_data    = DW'(kr);
    in_data    = DW'(inv);
    en_mult    = em;
    en_accuml  = ea;
    rst_accuml = ra;
    mul_shift  = 5'(ms);
    accu_shift = 5'(ash);
    en_out_mem = eo;
    model_step(kr, inv, em, ea, ra, ms, ash, eo);
    @(negedge clk);
    chk("mac_count", longint'(mac_count), longint'(m_cnt));
    chk("acc_ovf", longint'(acc_ovf), longint'(m_ovf));
  endtask

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // Monitor: every out_valid must match the oldest pending readout
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_valid: got 1 expected 0 with no readout pending");
      end else begin
        chk("out_data", longint'($signed(out_data)), longint'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    kr_data    = '0;
    in_data    = '0;
    en_mult    = 1'b0;
    en_accuml  = 1'b0;
    rst_accuml = 1'b0;
    mul_shift  = '0;
    accu_shift = '0;
    en_out_mem = 1'b0;
    #1;
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_mac_count", longint'(mac_count), 0);
    chk("rst_acc_ovf", longint'(acc_ovf), 0);
    @(negedge clk);
    rst = 1'b0;

    // 3*4 accumulated four times
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(3, 4, 1, 0, 0, 0, 0, 0);
    repeat (3) drive(3, 4, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("basic_acc", longint'($signed(out_data)), 48);
    chk("basic_cnt", longint'(mac_count), 4);

    // Negative product with arithmetic shift
    drive(-5, 7, 1, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("neg_shift_acc", longint'($signed(out_data)), -18);
    chk("neg_shift_cnt", longint'(mac_count), 1);

    // Clear coincident with a qualified accumulate
    drive(10, 10, 1, 0, 1, 0, 0, 0);
    drive(2, 5, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_add_acc", longint'($signed(out_data)), 10);
    chk("clr_add_cnt", longint'(mac_count), 1);

    // Output reduction of a value wider than DATA_W
    drive(1000, 1000, 1, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
`ifdef CONV_MAC_SATURATE_EN
    chk("reduce_big", longint'($signed(out_data)), 32767);
`else
    chk("reduce_big", longint'($signed(out_data)), 16960);
`endif
    chk("valid_pulse_hi", longint'(out_valid), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("valid_pulse_lo", longint'(out_valid), 0);

    // 1030 back-to-back MACs of 2^30: counter saturates, accumulator wraps
    drive(-32768, -32768, 1, 1, 1, 0, 0, 0);
    repeat (1029) drive(-32768, -32768, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    chk("sat_cnt", longint'(mac_count), 1023);
    chk("ovf_sticky", longint'(acc_ovf), 1);
    drive(0, 0, 0, 0, 0, 0, 31, 1);
    chk("wrap_acc", longint'($signed(out_data)), 3);

    // Reset between multiply and accumulate discards the product
    drive(2, 2, 1, 0, 0, 0, 0, 1);
    chk("pre_rst_valid", longint'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_out_data", longint'(out_data), 0);
    chk("async_out_valid", longint'(out_valid), 0);
    chk("async_mac_count", longint'(mac_count), 0);
    chk("async_acc_ovf", longint'(acc_ovf), 0);
    @(negedge clk);
    rst    = 1'b0;
    m_acc  = 0;
    m_prod = 0;
    m_vld  = 1'b0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(2, 2, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("post_rst_acc", longint'($signed(out_data)), 4);
    chk("post_rst_cnt", longint'(mac_count), 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int ms;
      ms = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
      drive(rnd16(), rnd16(),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0,
            ms,
            int'($urandom_range(0, 31)),
            $urandom_range(0, 2) == 0);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("readouts_drained", longint'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
